// File: rtl/covariance_builder_if.sv
// Sample-in / matrix-out bus for covariance_builder.
// The master drives frame control and samples; the slave returns the accumulated matrix.
interface covariance_builder_if #(
  parameter int unsigned SIZE_N = 8
);
  logic                                  start_i;
  logic                                  sample_valid_i;
  logic [SIZE_N-1:0][63:0]               sample_in_i;
  logic                                  sample_ready_o;
  logic [SIZE_N-1:0][SIZE_N-1:0][63:0]   matrix_out_o;
  logic [31:0]                           sample_count_o;
  logic                                  valid_o;

  modport master (
    output start_i, sample_valid_i, sample_in_i,
    input  sample_ready_o, matrix_out_o, sample_count_o, valid_o
  );

  modport slave (
    input  start_i, sample_valid_i, sample_in_i,
    output sample_ready_o, matrix_out_o, sample_count_o, valid_o
  );
endinterface

// File: rtl/covariance_builder.sv
// Streaming covariance accumulator: C[i][j] += s[i]*s[j] in IEEE double, one pair per cycle.
// Define COV_SYMMETRY_EN to walk only the upper triangle and mirror it once the frame is complete.
module covariance_builder #(
  parameter int unsigned SIZE_N      = 8,
  parameter int unsigned NUM_SAMPLES = 16
) (
  input logic                 clk,
  input logic                 rst,
  covariance_builder_if.slave bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StClear  = 3'd1;
  localparam logic [2:0] StWait   = 3'd2;
  localparam logic [2:0] StAccum  = 3'd3;
  localparam logic [2:0] StMirror = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;
  localparam int unsigned IdxW = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;

  function automatic int msb128(input logic [127:0] x);
    int p;
    p = 0;
    for (int k = 0; k < 128; k++) if (x[k]) p = k;
    return p;
  endfunction

  // x holds the exact (or sticky-collapsed) magnitude; biased exponent is e_base + msb(x).
  function automatic logic [63:0] round_pack(input logic s, input int e_base,
                                             input logic [127:0] x);
    logic [127:0] n;
    logic [10:0]  ef;
    logic         lost, rnd;
    int           p, e, sh;
    p    = msb128(x);
    e    = e_base + p;
    n    = x << (127 - p);
    ef   = e[10:0];
    lost = 1'b0;
    if (e >= 2047) return {s, 11'h7ff, 52'd0};
    if (e <= 0) begin
      sh   = (1 - e > 127) ? 127 : 1 - e;
      lost = |(n & ~({128{1'b1}} << sh));
      n    = n >> sh;
      ef   = 11'd0;
    end
    rnd = n[74] & (lost | (|n[73:0]) | n[75]);
    // Mantissa carry ripples into the exponent, covering renormalisation and overflow to Inf.
    return {s, {ef, n[126:75]} + 63'(rnd)};
  endfunction

  function automatic logic [63:0] fp_mul(input logic [63:0] a, input logic [63:0] b);
    logic         s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [52:0]  ma, mb;
    logic [105:0] prod;
    int           ea, eb;
    s      = a[63] ^ b[63];
    a_nan  = (&a[62:52]) & (|a[51:0]);
    b_nan  = (&b[62:52]) & (|b[51:0]);
    a_inf  = (&a[62:52]) & ~(|a[51:0]);
    b_inf  = (&b[62:52]) & ~(|b[51:0]);
    a_zero = ~(|a[62:0]);
    b_zero = ~(|b[62:0]);
    ea     = (a[62:52] == 11'd0) ? 1 : int'(a[62:52]);
    eb     = (b[62:52] == 11'd0) ? 1 : int'(b[62:52]);
    ma     = {|a[62:52], a[51:0]};
    mb     = {|b[62:52], b[51:0]};
    if (a_nan) return a | 64'h0008_0000_0000_0000;
    if (b_nan) return b | 64'h0008_0000_0000_0000;
    if ((a_inf && b_zero) || (b_inf && a_zero)) return 64'h7ff8_0000_0000_0000;
    if (a_inf || b_inf) return {s, 11'h7ff, 52'd0};
    if (a_zero || b_zero) return {s, 63'd0};
    prod = 106'(ma) * 106'(mb);
    return round_pack(s, ea + eb - 1149, {prod, 22'd0});
  endfunction

  function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x, y, big, sml, sum;
    logic        a_inf, b_inf, lost;
    int          ex, ey, d;
    a_inf = (&a[62:52]) & ~(|a[51:0]);
    b_inf = (&b[62:52]) & ~(|b[51:0]);
    if ((&a[62:52]) && (|a[51:0])) return a | 64'h0008_0000_0000_0000;
    if ((&b[62:52]) && (|b[51:0])) return b | 64'h0008_0000_0000_0000;
    if (a_inf && b_inf && (a[63] != b[63])) return 64'h7ff8_0000_0000_0000;
    if (a_inf) return a;
    if (b_inf) return b;
    if (b[62:0] > a[62:0]) begin
      x = b;
      y = a;
    end else begin
      x = a;
      y = b;
    end
    ex   = (x[62:52] == 11'd0) ? 1 : int'(x[62:52]);
    ey   = (y[62:52] == 11'd0) ? 1 : int'(y[62:52]);
    d    = (ex - ey > 64) ? 64 : ex - ey;
    big  = {1'b0, |x[62:52], x[51:0], 10'd0};
    sml  = {1'b0, |y[62:52], y[51:0], 10'd0};
    lost = |(sml & ~({64{1'b1}} << d));
    sml  = (sml >> d) | {63'd0, lost};
    sum  = (x[63] == y[63]) ? big + sml : big - sml;
    // Exact cancellation rounds to +0 unless both operands were negative.
    if (sum == 64'd0) return {x[63] & y[63], 63'd0};
    return round_pack(x[63], ex - 126, {sum, 64'd0});
  endfunction

  logic [2:0]                          state_q, state_d;
  logic [IdxW-1:0]                     i_q, i_d, j_q, j_d;
  logic [31:0]                         count_q, count_d;
  logic [SIZE_N-1:0][63:0]             samp_q;
  logic [SIZE_N-1:0][SIZE_N-1:0][63:0] acc_q;
  logic [63:0]                         term;
  logic                                last_pair;

  assign last_pair = (i_q == IdxW'(SIZE_N - 1)) && (j_q == IdxW'(SIZE_N - 1));
  assign term      = fp_add(acc_q[i_q][j_q], fp_mul(samp_q[i_q], samp_q[j_q]));

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    count_d = count_q;
    case (state_q)
      StIdle:   if (bus.start_i) state_d = StClear;
      StClear: begin
        count_d = 32'd0;
        i_d     = '0;
        j_d     = '0;
        state_d = StWait;
      end
      StWait:   if (bus.sample_valid_i) state_d = StAccum;
      StAccum: begin
        if (last_pair) begin
          count_d = count_q + 32'd1;
          i_d     = '0;
          j_d     = '0;
`ifdef COV_SYMMETRY_EN
          state_d = (count_d == NUM_SAMPLES) ? StMirror : StWait;
`else
          state_d = (count_d == NUM_SAMPLES) ? StDone : StWait;
`endif
        end else if (j_q == IdxW'(SIZE_N - 1)) begin
          i_d = i_q + 1'b1;
`ifdef COV_SYMMETRY_EN
          j_d = i_q + 1'b1;
`else
          j_d = '0;
`endif
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      StMirror: state_d = StDone;
      StDone:   if (bus.start_i) state_d = StClear;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      count_q <= 32'd0;
      samp_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      count_q <= count_d;
      if (state_q == StClear) acc_q <= '0;
      if (state_q == StWait && bus.sample_valid_i) samp_q <= bus.sample_in_i;
      if (state_q == StAccum) acc_q[i_q][j_q] <= term;
`ifdef COV_SYMMETRY_EN
      if (state_q == StMirror) begin
        for (int r = 0; r < int'(SIZE_N); r++) begin
          for (int c = 0; c < int'(SIZE_N); c++) begin
            if (c > r) acc_q[c][r] <= acc_q[r][c];
          end
        end
      end
`endif
    end
  end

  assign bus.sample_ready_o = (state_q == StWait);
  assign bus.valid_o        = (state_q == StDone);
  assign bus.matrix_out_o   = acc_q;
  assign bus.sample_count_o = count_q;

endmodule

// File: tb/tb_covariance_builder.sv
// Self-checking bench for covariance_builder: a 2-channel instance for the directed frames and an
// 8-channel instance for a random frame, both checked against a real-arithmetic covariance model.
module tb_covariance_builder;
`ifdef COV_SYMMETRY_EN
  localparam int P2 = 3;
  localparam int P8 = 36;
  localparam int Mir = 1;
`else
  localparam int P2 = 4;
  localparam int P8 = 64;
  localparam int Mir = 0;
`endif
  localparam int Lat2 = 1 + 2 * (1 + P2) + Mir;
  localparam int Lat8 = 1 + 16 * (1 + P8) + Mir;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  covariance_builder_if #(.SIZE_N(2)) b2 ();
  covariance_builder_if #(.SIZE_N(8)) b8 ();

  covariance_builder #(.SIZE_N(2), .NUM_SAMPLES(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  covariance_builder #(.SIZE_N(8), .NUM_SAMPLES(16)) dut8 (.clk(clk), .rst(rst), .bus(b8));

  int          n_checks = 0;
  int          n_fail = 0;
  real         stim2[3][2];
  real         stim8[16][8];
  logic [63:0] exp2[2][2];
  logic [63:0] exp8[8][8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Reference: C[i][j] = sum over t of x_i(t)*x_j(t), accumulated in sample order from +0.0.
  task automatic model2();
    real acc, p;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        acc = 0.0;
        for (int t = 0; t < 2; t++) begin
          p = stim2[t][i] * stim2[t][j];
          acc = acc + p;
        end
        exp2[i][j] = $realtobits(acc);
      end
  endtask

  task automatic model8();
    real acc, p;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        acc = 0.0;
        for (int t = 0; t < 16; t++) begin
          p = stim8[t][i] * stim8[t][j];
          acc = acc + p;
        end
        exp8[i][j] = $realtobits(acc);
      end
  endtask

  task automatic cmp2();
    int bi, bj;
    bit found;
    bi = 0; bj = 0; found = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (!found && b2.matrix_out_o[i][j] !== exp2[i][j]) begin
          bi = i; bj = j; found = 1;
        end
    check($sformatf("mat2[%0d][%0d]", bi, bj), b2.matrix_out_o[bi][bj], exp2[bi][bj]);
  endtask

  task automatic cmp8();
    int bi, bj;
    bit found;
    bi = 0; bj = 0; found = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (!found && b8.matrix_out_o[i][j] !== exp8[i][j]) begin
          bi = i; bj = j; found = 1;
        end
    check($sformatf("mat8[%0d][%0d]", bi, bj), b8.matrix_out_o[bi][bj], exp8[bi][bj]);
  endtask

  // Compare process: whenever a result is presented, it must match the model.
  always @(negedge clk) begin
    if (!rst && b2.valid_o === 1'b1) begin
      cmp2();
      check("count2_done", 64'(b2.sample_count_o), 64'd2);
    end
    if (!rst && b8.valid_o === 1'b1) begin
      cmp8();
      check("count8_done", 64'(b8.sample_count_o), 64'd16);
    end
  end

  task automatic feed2(input int gap, input bit hold);
    int w;
    for (int k = 0; k < 2; k++) begin
      w = 0;
      while (b2.sample_ready_o !== 1'b1 && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (w >= 100) check("ready2_timeout", 64'(b2.sample_ready_o), 64'd1);
      if (k > 0)
        for (int g = 0; g < gap; g++) begin
          check("ready2_gap", 64'(b2.sample_ready_o), 64'd1);
          @(negedge clk);
        end
      for (int c = 0; c < 2; c++) b2.sample_in_i[c] = $realtobits(stim2[k][c]);
      b2.sample_valid_i = 1'b1;
      @(negedge clk);
      if (hold) begin
        for (int c = 0; c < 2; c++) b2.sample_in_i[c] = $realtobits(stim2[k+1][c]);
      end else begin
        b2.sample_valid_i = 1'b0;
      end
    end
  endtask

  task automatic frame2(input int gap, input bit hold, input bit poke, output int lat);
    int l;
    l = 0;
    fork
      begin
        @(negedge clk);
        b2.start_i = 1'b1;
        @(posedge clk);
        #1 b2.start_i = 1'b0;
        check("valid2_drop", 64'(b2.valid_o), 64'd0);
        model2();
        while (b2.valid_o !== 1'b1 && l < 200) begin
          @(posedge clk);
          #1 l++;
        end
      end
      begin
        @(negedge clk);
        feed2(gap, hold);
      end
      begin
        if (poke) begin
          repeat (4) @(negedge clk);
          b2.start_i = 1'b1;
          @(negedge clk);
          b2.start_i = 1'b0;
        end
      end
    join
    lat = l;
  endtask

  task automatic feed8();
    int w;
    for (int k = 0; k < 16; k++) begin
      w = 0;
      while (b8.sample_ready_o !== 1'b1 && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (w >= 200) check("ready8_timeout", 64'(b8.sample_ready_o), 64'd1);
      for (int c = 0; c < 8; c++) b8.sample_in_i[c] = $realtobits(stim8[k][c]);
      b8.sample_valid_i = 1'b1;
      @(negedge clk);
      b8.sample_valid_i = 1'b0;
    end
  endtask

  task automatic frame8(output int lat);
    int l;
    l = 0;
    fork
      begin
        @(negedge clk);
        b8.start_i = 1'b1;
        @(posedge clk);
        #1 b8.start_i = 1'b0;
        model8();
        while (b8.valid_o !== 1'b1 && l < 2000) begin
          @(posedge clk);
          #1 l++;
        end
      end
      begin
        @(negedge clk);
        feed8();
      end
    join
    lat = l;
  endtask

  task automatic check_zero2(input string tag);
    check({tag, "_valid"}, 64'(b2.valid_o), 64'd0);
    check({tag, "_ready"}, 64'(b2.sample_ready_o), 64'd0);
    check({tag, "_count"}, 64'(b2.sample_count_o), 64'd0);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        check($sformatf("%s_m[%0d][%0d]", tag, i, j), b2.matrix_out_o[i][j], 64'd0);
  endtask

  task automatic check_basic(input string tag);
    check({tag, "_c00"}, b2.matrix_out_o[0][0], 64'h4024_0000_0000_0000);
    check({tag, "_c01"}, b2.matrix_out_o[0][1], 64'hbff0_0000_0000_0000);
    check({tag, "_c10"}, b2.matrix_out_o[1][0], 64'hbff0_0000_0000_0000);
    check({tag, "_c11"}, b2.matrix_out_o[1][1], 64'h4014_0000_0000_0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int bi, bj;
    bit found;
    b2.start_i = 1'b0; b2.sample_valid_i = 1'b0; b2.sample_in_i = '0;
    b8.start_i = 1'b0; b8.sample_valid_i = 1'b0; b8.sample_in_i = '0;
    stim2[0][0] = 1.0; stim2[0][1] = 2.0;
    stim2[1][0] = 3.0; stim2[1][1] = -1.0;
    stim2[2][0] = 7.0; stim2[2][1] = 9.0;

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_zero2("reset");
    check("reset8_valid", 64'(b8.valid_o), 64'd0);
    check("reset8_m77", b8.matrix_out_o[7][7], 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame, back-to-back samples.
    frame2(0, 1'b0, 1'b0, lat);
    check("lat_basic", 64'(lat), 64'(Lat2));
    @(negedge clk);
    check_basic("basic");
    check("basic_ready_done", 64'(b2.sample_ready_o), 64'd0);

    // Stall of 5 cycles between the samples.
    frame2(5, 1'b0, 1'b0, lat);
    check("lat_stall", 64'(lat), 64'(Lat2 + 5));
    @(negedge clk);
    check_basic("stall");

    // sample_valid held high through ACCUM, third sample offered, start pulsed in ACCUM.
    frame2(0, 1'b1, 1'b1, lat);
    check("lat_ignored", 64'(lat), 64'(Lat2));
    repeat (5) @(negedge clk);
    check("ignored_count", 64'(b2.sample_count_o), 64'd2);
    check("ignored_ready", 64'(b2.sample_ready_o), 64'd0);
    check("ignored_valid", 64'(b2.valid_o), 64'd1);
    check_basic("ignored");
    b2.sample_valid_i = 1'b0;

    // Restart from DONE with new data.
    for (int t = 0; t < 2; t++) begin
      stim2[t][0] = 0.5;
      stim2[t][1] = 0.5;
    end
    frame2(0, 1'b0, 1'b0, lat);
    check("lat_restart", 64'(lat), 64'(Lat2));
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        check($sformatf("restart_c%0d%0d", i, j), b2.matrix_out_o[i][j], 64'h3fe0_0000_0000_0000);

    // Reset during ACCUM of the second sample, then a clean frame.
    stim2[0][0] = 1.0; stim2[0][1] = 2.0;
    stim2[1][0] = 3.0; stim2[1][1] = -1.0;
    @(negedge clk);
    b2.start_i = 1'b1;
    @(posedge clk);
    #1 b2.start_i = 1'b0;
    feed2(0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero2("midreset");
    @(negedge clk);
    rst = 1'b0;
    frame2(0, 1'b0, 1'b0, lat);
    check("lat_after_reset", 64'(lat), 64'(Lat2));
    @(negedge clk);
    check_basic("after_reset");

    // Eight channels, sixteen random samples.
    for (int t = 0; t < 16; t++)
      for (int c = 0; c < 8; c++)
        stim8[t][c] = $itor($signed($urandom)) / 12345.678 / $itor(1 << $urandom_range(0, 12));
    frame8(lat);
    check("lat8", 64'(lat), 64'(Lat8));
    @(negedge clk);
    check("count8", 64'(b8.sample_count_o), 64'd16);
    bi = 0; bj = 1; found = 0;
    for (int i = 0; i < 8; i++)
      for (int j = i + 1; j < 8; j++)
        if (!found && b8.matrix_out_o[i][j] !== b8.matrix_out_o[j][i]) begin
          bi = i; bj = j; found = 1;
        end
    check($sformatf("sym8[%0d][%0d]", bi, bj), b8.matrix_out_o[bj][bi], exp8[bi][bj]);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
